// File: rtl/calc_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_disp_pkg
// Description : Shared constants and types for the calculator display path.
//               NUM_DIGITS  - number of multiplexed digits
//               SEG_BLANK   - all segments off (active-low)
//               SEG_DASH    - segment g only, shown for non-decimal nibbles
//               dig_idx_t   - scan index type
// Revision    : 1.0 - initial release
// ============================================================================
package calc_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [$clog2(NUM_DIGITS)-1:0] dig_idx_t;

  localparam dig_idx_t LAST_DIGIT = dig_idx_t'(NUM_DIGITS - 1);

endpackage : calc_disp_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational nibble to seven-segment decoder, active-low,
//               segment order {g,f,e,d,c,b,a}. Nibbles above 9 show a dash.
// Ports       : nibble (in 4)  - value to decode
//               seg    (out 7) - active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import calc_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux
// Description : Time-multiplexed 4-digit common-anode seven-segment driver.
//               A strobed BCD word is held pending and promoted to the
//               displayed word only at frame boundaries, so a scan never
//               mixes two values. Optional leading-zero blanking.
// Ports       : clk        (in)     - system clock, rising edge
//               rst_n      (in)     - synchronous active-low reset
//               bcd        (in 16)  - packed BCD, [3:0] = digit 0
//               bcd_valid  (in)     - one-cycle strobe sampling bcd
//               blank_lz   (in)     - level, blank leading zeros
//               an         (out 4)  - digit enables, active-low one-hot
//               seg        (out 7)  - segments {g,f,e,d,c,b,a}, active-low
//               dp         (out)    - decimal point, always off (1)
//               frame_done (out)    - one-cycle pulse after each frame wrap
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int                 c_div_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(REFRESH_DIV - 1);

  logic [c_div_w-1:0]    r_div_cnt;
  dig_idx_t              r_dig_idx;
  logic [15:0]           r_pend;
  logic [15:0]           r_disp;
  logic [3:0]            r_an;
  logic [6:0]            r_seg;
  logic                  r_frame_done;

  logic                  w_div_wrap;
  logic                  w_frame_bnd;
  logic [15:0]           w_pend_next;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]            w_an_sel;

  assign w_div_wrap  = (r_div_cnt == c_div_last);
  assign w_frame_bnd = w_div_wrap && (r_dig_idx == LAST_DIGIT);

  // A strobe on the boundary cycle goes straight to the display register.
  assign w_pend_next = bcd_valid ? bcd : r_pend;

  // w_lz[k]: digit k and every digit above it are zero. Digit 0 is never
  // a leading zero, so its bit is tied low.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_units
      assign w_lz[k] = 1'b0;
    end else if (k == NUM_DIGITS - 1) begin : g_top
      assign w_lz[k] = (r_disp[4*k +: 4] == 4'd0);
    end else begin : g_mid
      assign w_lz[k] = (r_disp[4*k +: 4] == 4'd0) && w_lz[k+1];
    end
  end

  assign w_nib    = r_disp[{r_dig_idx, 2'b00} +: 4];
  assign w_blank  = blank_lz && w_lz[r_dig_idx];
  assign w_an_sel = ~(4'b0001 << r_dig_idx);

  bcd_to_7seg u_dec (
    .nibble (w_nib),
    .seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_dig_idx    <= '0;
      r_pend       <= '0;
      r_disp       <= '0;
      r_an         <= 4'hF;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_dig_idx <= r_dig_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      r_pend <= w_pend_next;
      if (w_frame_bnd) begin
        r_disp <= w_pend_next;
      end

      r_an         <= w_blank ? 4'hF : w_an_sel;
      r_seg        <= w_blank ? SEG_BLANK : w_seg;
      r_frame_done <= w_frame_bnd;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = 1'b1;
  assign frame_done = r_frame_done;

endmodule : bcd_display_mux
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_mux
// Description : Self-checking bench for bcd_display_mux with REFRESH_DIV=4.
//               A cycle-level reference model derived from frame arithmetic
//               predicts every output each cycle; table vectors and short
//               directed sequences check whole frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux;

  localparam int R = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  bcd_display_mux #(.REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  glyph [16];
  int          m_n;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  end

  // Position within the frame is cycles-since-reset modulo the frame length;
  // the lit slot is that position divided by the slot length.
  always @(posedge clk) begin : model
    int          pos;
    int          slot;
    logic        bnd;
    logic [15:0] upper;
    logic [15:0] np;
    if (!rst_n) begin
      m_n    <= 0;
      m_pend <= '0;
      m_disp <= '0;
      e_an   <= 4'hF;
      e_seg  <= 7'h7F;
      e_fd   <= 1'b0;
    end else begin
      pos   = m_n % (4 * R);
      slot  = pos / R;
      bnd   = (pos == 4 * R - 1);
      upper = m_disp >> (4 * slot);
      if (blank_lz && slot > 0 && upper == 16'h0) begin
        e_an  <= 4'hF;
        e_seg <= 7'h7F;
      end else begin
        e_an  <= ~(4'b0001 << slot);
        e_seg <= glyph[upper[3:0]];
      end
      e_fd <= bnd;
      np = bcd_valid ? bcd : m_pend;
      m_pend <= np;
      if (bnd) m_disp <= np;
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_an", {4'h0, an}, {4'h0, e_an});
    chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
    chk("model_dp", {7'h0, dp}, 8'h01);
    chk("model_frame_done", {7'h0, frame_done}, {7'h0, e_fd});
  end

  // ---------------- directed helpers ----------------
  typedef struct packed {
    logic [15:0]      bcd;
    logic             blz;
    logic [3:0][6:0]  seg;  // [k] = digit k
    logic [3:0][3:0]  an;
  } vec_t;

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 8 * R + 4 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_fd: got timeout expected frame_done pulse at %0t", $time);
    end
  endtask

  // Called at the negedge where frame_done is high; the new frame's digit 0
  // appears on the next cycle.
  task automatic check_frame(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : R) @(negedge clk);
      chk($sformatf("frame_%h_an%0d", v.bcd, k), {4'h0, an}, {4'h0, v.an[k]});
      chk($sformatf("frame_%h_seg%0d", v.bcd, k), {1'b0, seg}, {1'b0, v.seg[k]});
    end
  endtask

  task automatic strobe(input logic [15:0] val);
    bcd       = val;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{bcd:16'h0255, blz:1'b0, seg:{7'h40, 7'h24, 7'h12, 7'h12}, an:{4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{bcd:16'h0007, blz:1'b1, seg:{7'h7F, 7'h7F, 7'h7F, 7'h78}, an:{4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[2] = '{bcd:16'h0000, blz:1'b1, seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, an:{4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[3] = '{bcd:16'h00A3, blz:1'b1, seg:{7'h7F, 7'h7F, 7'h3F, 7'h30}, an:{4'hF, 4'hF, 4'hD, 4'hE}};
    vecs[4] = '{bcd:16'h0128, blz:1'b0, seg:{7'h40, 7'h79, 7'h24, 7'h00}, an:{4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[5] = '{bcd:16'h9999, blz:1'b1, seg:{7'h10, 7'h10, 7'h10, 7'h10}, an:{4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[6] = '{bcd:16'h1000, blz:1'b1, seg:{7'h79, 7'h40, 7'h40, 7'h40}, an:{4'h7, 4'hB, 4'hD, 4'hE}};

    rst_n     = 1'b0;
    bcd       = '0;
    bcd_valid = 1'b0;
    blank_lz  = 1'b0;

    // Reset values while held in reset.
    repeat (3) begin
      @(negedge clk);
      chk("reset_an", {4'h0, an}, 8'h0F);
      chk("reset_seg", {1'b0, seg}, 8'h7F);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_an", {4'h0, an}, 8'h0E);
    chk("post_reset_seg", {1'b0, seg}, 8'h40);

    // Table vectors: strobe mid-frame, check the frame after the boundary.
    foreach (vecs[i]) begin
      repeat (3) @(negedge clk);
      blank_lz = vecs[i].blz;
      strobe(vecs[i].bcd);
      wait_fd();
      check_frame(vecs[i]);
    end

    // Last strobe in a frame wins.
    blank_lz = 1'b0;
    wait_fd();
    strobe(16'h00A3);
    @(negedge clk);
    strobe(16'h0128);
    wait_fd();
    check_frame(vecs[4]);

    // Strobe exactly on the boundary cycle overrides the earlier pending value.
    wait_fd();
    @(negedge clk);
    @(negedge clk);
    strobe(16'h9999);
    repeat (4 * R - 4) @(negedge clk);
    bcd       = 16'h4321;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
    chk("coincident_frame_done", {7'h0, frame_done}, 8'h01);
    check_frame('{bcd:16'h4321, blz:1'b0, seg:{7'h19, 7'h30, 7'h24, 7'h79}, an:{4'h7, 4'hB, 4'hD, 4'hE}});

    // Reset mid-frame discards a pending value.
    repeat (3) @(negedge clk);
    strobe(16'h5678);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_an", {4'h0, an}, 8'h0F);
    chk("midreset_seg", {1'b0, seg}, 8'h7F);
    chk("midreset_frame_done", {7'h0, frame_done}, 8'h00);
    rst_n = 1'b1;
    wait_fd();
    check_frame('{bcd:16'h0000, blz:1'b0, seg:{7'h40, 7'h40, 7'h40, 7'h40}, an:{4'h7, 4'hB, 4'hD, 4'hE}});

    // Randomized traffic against the model.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bcd_valid = ($urandom % 6 == 0);
      for (int d = 0; d < 4; d++) begin
        bcd[4*d +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
      end
      if ($urandom % 20 == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom % 300 != 0);
    end
    @(negedge clk);
    bcd_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bcd_display_mux
`default_nettype wire
